// File: rtl/branch_hazard_unit_pkg.sv
// Shared definitions for the branch hazard unit: FSM encodings, counter
// sizing and the hazard-depth rule used by the ID-stage branch logic.
package branch_hazard_unit_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      STALL = 1'b1
   } state_t;

   localparam int unsigned     CNT_W   = 16;
   localparam logic [CNT_W-1:0] CNT_SAT = 16'hFFFF;

   // A producer only matters if it writes a real register that the branch reads.
   function automatic logic reg_match(input logic [4:0] rd,
                                      input logic [4:0] rs,
                                      input logic [4:0] rt);
      return (rd != 5'd0) && ((rd == rs) || (rd == rt));
   endfunction

   // Number of bubbles needed before the branch operands can be compared in ID.
   function automatic logic [1:0] hazard_depth(input logic       id_ex_reg_write,
                                               input logic       id_ex_mem_read,
                                               input logic [4:0] id_ex_rd,
                                               input logic       ex_mem_mem_read,
                                               input logic [4:0] ex_mem_rd,
                                               input logic [4:0] rs,
                                               input logic [4:0] rt);
      logic id_hit;
      logic ex_hit;
      id_hit = reg_match(id_ex_rd, rs, rt);
      ex_hit = reg_match(ex_mem_rd, rs, rt);
      if (id_ex_mem_read && id_hit)
         return 2'd2;
      else if (id_ex_reg_write && id_hit)
         return 2'd1;
      else if (ex_mem_mem_read && ex_hit)
         return 2'd1;
      else
         return 2'd0;
   endfunction

endpackage

// File: rtl/branch_hazard_unit_if.sv
// Pipeline-side signal bundle of the branch hazard unit.
interface branch_hazard_unit_if;
   import branch_hazard_unit_pkg::*;

   logic             cur_branch;
   logic             is_bne;
   logic [4:0]       IF_ID_rs;
   logic [4:0]       IF_ID_rt;
   logic             ID_EX_reg_write;
   logic             ID_EX_mem_read;
   logic [4:0]       ID_EX_rd;
   logic             EX_MEM_mem_read;
   logic [4:0]       EX_MEM_rd;
   logic             operands_equal;

   logic             pc_write;
   logic             IF_ID_write;
   logic             ID_EX_bubble;
   logic             pc_src;
   logic             IF_ID_flush;
   logic [CNT_W-1:0] stall_cycles;
   logic [CNT_W-1:0] taken_flushes;
   logic             state;

   modport master (
      output cur_branch, is_bne, IF_ID_rs, IF_ID_rt, ID_EX_reg_write,
             ID_EX_mem_read, ID_EX_rd, EX_MEM_mem_read, EX_MEM_rd, operands_equal,
      input  pc_write, IF_ID_write, ID_EX_bubble, pc_src, IF_ID_flush,
             stall_cycles, taken_flushes, state
   );

   modport slave (
      input  cur_branch, is_bne, IF_ID_rs, IF_ID_rt, ID_EX_reg_write,
             ID_EX_mem_read, ID_EX_rd, EX_MEM_mem_read, EX_MEM_rd, operands_equal,
      output pc_write, IF_ID_write, ID_EX_bubble, pc_src, IF_ID_flush,
             stall_cycles, taken_flushes, state
   );

endinterface

// File: rtl/branch_hazard_unit_sat_counter16.sv
// Saturating event counter; holds at the saturation value instead of wrapping.
module sat_counter16
   import branch_hazard_unit_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   // Count one event per cycle, sticking at full scale.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         count <= '0;
      else if (inc && (count != CNT_SAT))
         count <= count + CNT_W'(1);
   end

endmodule

// File: rtl/branch_hazard_unit.sv
// ID-stage branch hazard unit: stalls a beq/bne until its operands can be
// forwarded, then resolves it once and flushes IF/ID when taken.
//
//   state | meaning
//   IDLE  | evaluate branch: stall for N=1, enter STALL for N=2, else resolve
//   STALL | second bubble of a load-use branch; hazard inputs ignored
module branch_hazard_unit
   import branch_hazard_unit_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   branch_hazard_unit_if.slave  bus
);

   state_t     state_q;
   state_t     state_d;
   logic [1:0] remain_q;
   logic [1:0] remain_d;
   logic [1:0] depth;
   logic       stall;
   logic       taken;

   // State and remaining-bubble register; reset abandons any stall in progress.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         remain_q <= '0;
      end else begin
         state_q  <= state_d;
         remain_q <= remain_d;
      end
   end

   // Next state plus stall/resolve decision; outputs stay pass-through during reset.
   always_comb begin
      state_d  = state_q;
      remain_d = remain_q;
      stall    = 1'b0;
      taken    = 1'b0;
      depth    = hazard_depth(bus.ID_EX_reg_write, bus.ID_EX_mem_read, bus.ID_EX_rd,
                              bus.EX_MEM_mem_read, bus.EX_MEM_rd,
                              bus.IF_ID_rs, bus.IF_ID_rt);
      if (!rst) begin
         case (state_q)
            IDLE: begin
               if (bus.cur_branch) begin
                  if (depth != 2'd0) begin
                     stall = 1'b1;
                     if (depth == 2'd2) begin
                        state_d  = STALL;
                        remain_d = 2'd1;
                     end
                  end else begin
                     taken = bus.operands_equal ^ bus.is_bne;
                  end
               end
            end
            STALL: begin
               stall    = 1'b1;
               remain_d = (remain_q == 2'd0) ? 2'd0 : remain_q - 2'd1;
               state_d  = (remain_d == 2'd0) ? IDLE : STALL;
            end
            default: begin
               state_d  = IDLE;
               remain_d = '0;
            end
         endcase
      end
   end

   // Pipeline control derived from the stall/resolve decision.
   always_comb begin
      bus.pc_write     = ~stall;
      bus.IF_ID_write  = ~stall;
      bus.ID_EX_bubble = stall;
      bus.pc_src       = taken;
      bus.IF_ID_flush  = taken;
      bus.state        = state_q;
   end

   sat_counter16 u_stall_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (stall),
      .count (bus.stall_cycles)
   );

   sat_counter16 u_flush_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (taken),
      .count (bus.taken_flushes)
   );

endmodule

// File: tb/tb_branch_hazard_unit.sv
// Directed bench for branch_hazard_unit with a queue-based scoreboard.
module tb_branch_hazard_unit;

   localparam logic [4:0] OUT_P = 5'b11000;  // {pc_write, IF_ID_write, bubble, pc_src, flush}
   localparam logic [4:0] OUT_S = 5'b00100;
   localparam logic [4:0] OUT_T = 5'b11011;

   typedef struct {
      string       nm;
      logic [4:0]  outs;
      logic        st;
      logic [15:0] sc;
      logic [15:0] tf;
   } exp_t;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_pass;
   exp_t exp_q[$];

   branch_hazard_unit_if bus();

   branch_hazard_unit dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: got simulation still running, want finish");
      $fatal(1, "timeout");
   end

   // Drive one cycle of inputs just after the edge; queue the expected response.
   task automatic cyc(input string nm, input logic r, input logic br, input logic bne,
                      input logic [4:0] rs, input logic [4:0] rt,
                      input logic idw, input logic idm, input logic [4:0] idrd,
                      input logic exm, input logic [4:0] exrd, input logic eq,
                      input logic [4:0] eo, input logic est,
                      input logic [15:0] esc, input logic [15:0] etf, input bit chk);
      exp_t e;
      @(posedge clk);
      #1;
      rst                 = r;
      bus.cur_branch      = br;
      bus.is_bne          = bne;
      bus.IF_ID_rs        = rs;
      bus.IF_ID_rt        = rt;
      bus.ID_EX_reg_write = idw;
      bus.ID_EX_mem_read  = idm;
      bus.ID_EX_rd        = idrd;
      bus.EX_MEM_mem_read = exm;
      bus.EX_MEM_rd       = exrd;
      bus.operands_equal  = eq;
      if (chk) begin
         e.nm = nm; e.outs = eo; e.st = est; e.sc = esc; e.tf = etf;
         exp_q.push_back(e);
      end
   endtask

   // Monitor: mid-cycle, compare DUT outputs against the oldest expectation.
   initial begin
      exp_t       e;
      logic [4:0] act;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            act = {bus.pc_write, bus.IF_ID_write, bus.ID_EX_bubble, bus.pc_src, bus.IF_ID_flush};
            n_checks++;
            if (act === e.outs && bus.state === e.st &&
                bus.stall_cycles === e.sc && bus.taken_flushes === e.tf)
               n_pass++;
            else
               $display("FAIL %s: got outs=%b state=%b stall=%h taken=%h, want outs=%b state=%b stall=%h taken=%h",
                        e.nm, act, bus.state, bus.stall_cycles, bus.taken_flushes,
                        e.outs, e.st, e.sc, e.tf);
         end
      end
   end

   initial begin
      n_checks = 0;
      n_pass   = 0;
      rst = 1'b1;
      bus.cur_branch = 0; bus.is_bne = 0; bus.IF_ID_rs = 0; bus.IF_ID_rt = 0;
      bus.ID_EX_reg_write = 0; bus.ID_EX_mem_read = 0; bus.ID_EX_rd = 0;
      bus.EX_MEM_mem_read = 0; bus.EX_MEM_rd = 0; bus.operands_equal = 0;

      //   name               rst br bne rs rt idw idm idrd exm exrd eq  outs  st stall     taken chk
      cyc("reset_hold",        1, 1, 0,  8, 0, 0,  1,  8,   0,  0,   0, OUT_P, 0, 16'd0,    16'd0, 1);
      cyc("lu_stall1",         0, 1, 0,  8, 0, 0,  1,  8,   0,  0,   0, OUT_S, 0, 16'd0,    16'd0, 1);
      cyc("lu_stall2",         0, 1, 0,  8, 0, 0,  1,  8,   0,  0,   0, OUT_S, 1, 16'd1,    16'd0, 1);
      cyc("lu_resolve",        0, 1, 0,  8, 0, 0,  0,  0,   0,  0,   1, OUT_T, 0, 16'd2,    16'd0, 1);
      cyc("lu_after",          0, 0, 0,  0, 0, 0,  0,  0,   0,  0,   0, OUT_P, 0, 16'd2,    16'd1, 1);
      cyc("alu_stall",         0, 1, 0,  3, 9, 1,  0,  9,   0,  0,   1, OUT_S, 0, 16'd2,    16'd1, 1);
      cyc("alu_resolve",       0, 1, 0,  3, 9, 0,  0,  0,   0,  9,   1, OUT_T, 0, 16'd3,    16'd1, 1);
      cyc("alu_after",         0, 0, 0,  0, 0, 0,  0,  0,   0,  0,   0, OUT_P, 0, 16'd3,    16'd2, 1);
      cyc("mem_load_stall",    0, 1, 0,  7, 0, 0,  0,  0,   1,  7,   0, OUT_S, 0, 16'd3,    16'd2, 1);
      cyc("beq_not_taken",     0, 1, 0,  7, 0, 0,  0,  0,   0,  0,   0, OUT_P, 0, 16'd4,    16'd2, 1);
      cyc("rd0_filter",        0, 1, 0,  0, 0, 0,  1,  0,   1,  0,   1, OUT_T, 0, 16'd4,    16'd2, 1);
      cyc("rd0_after",         0, 0, 0,  0, 0, 0,  0,  0,   0,  0,   0, OUT_P, 0, 16'd4,    16'd3, 1);
      cyc("bne_not_taken",     0, 1, 1,  1, 2, 0,  0,  0,   0,  0,   1, OUT_P, 0, 16'd4,    16'd3, 1);
      cyc("bne_nt_after",      0, 0, 0,  0, 0, 0,  0,  0,   0,  0,   0, OUT_P, 0, 16'd4,    16'd3, 1);
      cyc("bne_taken",         0, 1, 1,  1, 2, 0,  0,  0,   0,  0,   0, OUT_T, 0, 16'd4,    16'd3, 1);
      cyc("bne_t_after",       0, 0, 0,  0, 0, 0,  0,  0,   0,  0,   0, OUT_P, 0, 16'd4,    16'd4, 1);
      cyc("rd_mismatch",       0, 1, 0,  6, 7, 1,  1,  5,   1,  4,   0, OUT_P, 0, 16'd4,    16'd4, 1);
      cyc("no_branch_hazard",  0, 0, 0,  8, 0, 0,  1,  8,   0,  0,   0, OUT_P, 0, 16'd4,    16'd4, 1);
      cyc("rst_stall1",        0, 1, 0,  8, 0, 0,  1,  8,   0,  0,   0, OUT_S, 0, 16'd4,    16'd4, 1);
      cyc("rst_in_stall",      1, 1, 0,  8, 0, 0,  1,  8,   0,  0,   0, OUT_P, 0, 16'd0,    16'd0, 1);
      cyc("rst_release",       0, 0, 0,  8, 0, 0,  1,  8,   0,  0,   0, OUT_P, 0, 16'd0,    16'd0, 1);

      for (int i = 0; i < 65534; i++)
         cyc("sat_fill",       0, 1, 0,  3, 9, 1,  0,  9,   0,  0,   0, OUT_S, 0, 16'd0,    16'd0, 0);
      cyc("sat_fffe",          0, 1, 0,  3, 9, 1,  0,  9,   0,  0,   0, OUT_S, 0, 16'hFFFE, 16'd0, 1);
      cyc("sat_ffff",          0, 1, 0,  3, 9, 1,  0,  9,   0,  0,   0, OUT_S, 0, 16'hFFFF, 16'd0, 1);
      cyc("sat_hold",          0, 0, 0,  0, 0, 0,  0,  0,   0,  0,   0, OUT_P, 0, 16'hFFFF, 16'd0, 1);

      repeat (3) @(posedge clk);
      if (exp_q.size() != 0) begin
         n_checks++;
         $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/branch_hazard_unit.md
BRANCH_HAZARD_UNIT -- requirements
Module: branch_hazard_unit

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset, with ports named clk and rst.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous active-high reset.
REQ-004 cur_branch  input  1  a beq/bne instruction is in ID.
REQ-005 is_bne  input  1  1 = bne, 0 = beq; valid when cur_branch=1.
REQ-006 IF_ID_rs, IF_ID_rt  input  5 each  branch source registers.
REQ-007 ID_EX_reg_write, ID_EX_mem_read  input  1 each  control bits of the instruction in EX.
REQ-008 ID_EX_rd  input  5  destination of the instruction in EX.
REQ-009 EX_MEM_mem_read  input  1  a load is in MEM.
REQ-010 EX_MEM_rd  input  5  destination of the instruction in MEM.
REQ-011 operands_equal  input  1  ID comparator result on the forwarded branch operands.
REQ-012 pc_write  output  1  0 freezes the PC.
REQ-013 IF_ID_write  output  1  0 freezes IF/ID.
REQ-014 ID_EX_bubble  output  1  1 zeroes ID/EX control (inserts a nop).
REQ-015 pc_src  output  1  1 selects the branch target.
REQ-016 IF_ID_flush  output  1  1 zeroes IF/ID.
REQ-017 stall_cycles, taken_flushes  output  16 each  saturating event counters.
REQ-018 state  output  1  0=IDLE, 1=STALL; debug only.

Function
REQ-019 A match SHALL count only when the producer rd is non-zero and equals IF_ID_rs or IF_ID_rt.
REQ-020 Hazard depth N SHALL be computed as follows.
- N=2 when ID_EX_mem_read is set and ID_EX_rd matches.
- Otherwise N=1 when ID_EX_reg_write is set and ID_EX_rd matches.
- Otherwise N=1 when EX_MEM_mem_read is set and EX_MEM_rd matches.
- Otherwise N=0.
REQ-021 In IDLE with cur_branch=1 and N>0, the block SHALL stall in that cycle: pc_write=0, IF_ID_write=0, ID_EX_bubble=1, pc_src=0, IF_ID_flush=0.
REQ-022 In that cycle, N=2 SHALL transition to STALL with remaining count 1; N=1 SHALL stay in IDLE.
REQ-023 In STALL, the block SHALL stall as in REQ-021, ignore hazard inputs, decrement the remaining count, and return to IDLE when the count reaches 0.
REQ-024 In IDLE with cur_branch=1 and N=0, the branch SHALL resolve as taken = operands_equal XOR is_bne.
REQ-025 When taken=1, pc_src=1 and IF_ID_flush=1 for exactly that cycle; pc_write=1 and IF_ID_write=1.
REQ-026 When taken=0, all outputs SHALL stay at their pass-through values.
REQ-027 Pass-through values: pc_write=1, IF_ID_write=1, ID_EX_bubble=0, pc_src=0, IF_ID_flush=0.
REQ-028 When cur_branch=0 in IDLE, the outputs SHALL take their pass-through values and state SHALL not change.
REQ-029 Stall and flush outputs SHALL be combinational from state and inputs, with zero-cycle latency.
REQ-030 stall_cycles SHALL increment once per cycle with ID_EX_bubble=1 and saturate at 16'hFFFF.
REQ-031 taken_flushes SHALL increment once per cycle with IF_ID_flush=1 and saturate at 16'hFFFF.
REQ-032 A stall and a resolution SHALL never occur in the same cycle; stall has priority.
REQ-033 A branch resolves at most once; it is resolved in the first hazard-free IDLE cycle.

Reset
REQ-034 rst=1 SHALL immediately force state=IDLE, the remaining count to 0 and both counters to 0.
REQ-035 While rst is asserted, outputs SHALL take their pass-through values.
REQ-036 Reset asserted in STALL SHALL abandon the stall; the first cycle after release evaluates the inputs afresh.

Structure
REQ-037 The shared pipeline package SHALL hold the state encodings IDLE/STALL, the counter width (16) and the saturation value.
REQ-038 A sub-module sat_counter16 (clk, rst, inc, count) SHALL implement both counters and be instantiated twice.

Verification
REQ-039 Load-use branch: ID_EX_mem_read=1, ID_EX_rd=8, IF_ID_rs=8, cur_branch=1.
- Response: two stall cycles, with state 0->1->0.
- Then the branch resolves, and stall_cycles=2.
REQ-040 ALU-to-branch: ID_EX_reg_write=1, ID_EX_rd=9, IF_ID_rt=9.
- Response: one stall cycle, then resolution.
- With operands_equal=1 and is_bne=0: pc_src=1 and IF_ID_flush=1 for one cycle, and taken_flushes=1.
REQ-041 rd=0 filter: ID_EX_mem_read=1, ID_EX_rd=0, IF_ID_rs=0.
- Response: no stall, and immediate resolution.
REQ-042 bne not taken: N=0, operands_equal=1, is_bne=1.
- Response: pc_src=0, IF_ID_flush=0, and the counters are unchanged.
REQ-043 Reset in STALL: assert rst during the second stall cycle of the REQ-039 case.
- Response: state=0 and the counters read 0 immediately.
- After release with cur_branch=0: pc_write=1.
REQ-044 Saturation: preload the 65535 stall events.
- Response: after one more stall, stall_cycles remains 16'hFFFF.
